// File: rtl/rs_int_pkg.sv
// rtl/rs_int_pkg.sv - shared sizes, ALU opcodes and entry layout for the integer reservation station
//   Contents: RS/ROB sizing, alu_op_e opcode encoding shared with the decoder,
//             rs_entry_t station entry, pick_lowest priority helper.
package rs_int_pkg;

    localparam int RS_SIZE      = 8;
    localparam int RS_SIZE_BIT  = 3;
    localparam int ROB_SIZE_BIT = 5;
    localparam int RS_OP_BIT    = 4;

    // Occupancy counter is one bit wider than the index so it can hold RS_SIZE.
    localparam logic [RS_SIZE_BIT:0] CNT_FULL   = 4'd8;
    localparam logic [RS_SIZE_BIT:0] CNT_ALMOST = 4'd7;

    typedef enum logic [RS_OP_BIT-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_EQ   = 4'd10,
        ALU_NE   = 4'd11,
        ALU_LT   = 4'd12,
        ALU_GE   = 4'd13,
        ALU_LTU  = 4'd14,
        ALU_GEU  = 4'd15
    } alu_op_e;

    typedef struct packed {
        logic                    busy;
        logic [RS_OP_BIT-1:0]    op;
        logic [31:0]             vj;
        logic [ROB_SIZE_BIT-1:0] qj;
        logic                    has_qj;
        logic [31:0]             vk;
        logic [ROB_SIZE_BIT-1:0] qk;
        logic                    has_qk;
        logic [ROB_SIZE_BIT-1:0] rob_id;
    } rs_entry_t;

    // Returns {found, index} of the lowest set bit.
    function automatic logic [RS_SIZE_BIT:0] pick_lowest(input logic [RS_SIZE-1:0] v);
        logic [RS_SIZE_BIT:0] r;
        r = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = {1'b1, RS_SIZE_BIT'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_alu.sv
// rtl/rs_alu.sv - single-cycle combinational integer ALU for the reservation station
//   Ports: op (alu_op_e code), a (operand 1), b (operand 2 / immediate), result.
module rs_alu
    import rs_int_pkg::*;
(
    input  logic [RS_OP_BIT-1:0] op,
    input  logic [31:0]          a,
    input  logic [31:0]          b,
    output logic [31:0]          result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = 32'($signed(a) >>> b[4:0]);
            ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'd0, a < b};
            ALU_EQ:   result = {31'd0, a == b};
            ALU_NE:   result = {31'd0, a != b};
            ALU_LT:   result = {31'd0, $signed(a) < $signed(b)};
            ALU_GE:   result = {31'd0, $signed(a) >= $signed(b)};
            ALU_LTU:  result = {31'd0, a < b};
            ALU_GEU:  result = {31'd0, a >= b};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/rs_int.sv
// rtl/rs_int.sv - integer reservation station: buffer, wakeup, select, dispatch to ALU
//   Ports: clk_in/rst_in (async, active-high), rdy_in (global enable), rob_clear (flush),
//          issue_* (decoder issue), rs_full (back-pressure), lsb_* (LSB broadcast),
//          rs_fi/rs_value/rs_rob_id (registered result broadcast to the ROB).
module rs_int
    import rs_int_pkg::*;
(
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    rob_clear,
    input  logic                    issue_valid,
    input  logic [RS_OP_BIT-1:0]    issue_op,
    input  logic [31:0]             issue_vj,
    input  logic                    issue_has_qj,
    input  logic [ROB_SIZE_BIT-1:0] issue_qj,
    input  logic [31:0]             issue_vk,
    input  logic                    issue_has_qk,
    input  logic [ROB_SIZE_BIT-1:0] issue_qk,
    input  logic [ROB_SIZE_BIT-1:0] issue_rob_id,
    output logic                    rs_full,
    input  logic                    lsb_fi,
    input  logic [31:0]             lsb_value,
    input  logic [ROB_SIZE_BIT-1:0] lsb_rob_id,
    output logic                    rs_fi,
    output logic [31:0]             rs_value,
    output logic [ROB_SIZE_BIT-1:0] rs_rob_id
);

    rs_entry_t              ent [RS_SIZE];
    logic [RS_SIZE_BIT:0]   count;

    logic [RS_SIZE-1:0]     free_vec;
    logic [RS_SIZE-1:0]     ready_vec;
    logic                   free_valid;
    logic [RS_SIZE_BIT-1:0] free_idx;
    logic                   sel_valid;
    logic [RS_SIZE_BIT-1:0] sel_idx;
    logic [31:0]            alu_result;

    logic                   iss_accept;
    logic [31:0]            iss_vj;
    logic                   iss_has_qj;
    logic [31:0]            iss_vk;
    logic                   iss_has_qk;
    logic [RS_SIZE_BIT:0]   count_next;

    // Readiness is judged on registered flags, so an entry woken this cycle waits one more.
    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            free_vec[i]  = !ent[i].busy;
            ready_vec[i] = ent[i].busy && !ent[i].has_qj && !ent[i].has_qk;
        end
        {free_valid, free_idx} = pick_lowest(free_vec);
        {sel_valid, sel_idx}   = pick_lowest(ready_vec);
    end

    // Full is conservative: with one slot left, an issue that is not offset by a
    // dispatch this cycle already consumes the last slot.
    assign rs_full = (count == CNT_FULL) ||
                     ((count == CNT_ALMOST) && issue_valid && !sel_valid);

    // Issue-time bypass: LSB is checked first so it wins on a (should-not-happen) tag tie.
    always_comb begin
        iss_vj     = issue_vj;
        iss_has_qj = issue_has_qj;
        if (issue_has_qj) begin
            if (lsb_fi && (lsb_rob_id == issue_qj)) begin
                iss_vj     = lsb_value;
                iss_has_qj = 1'b0;
            end else if (rs_fi && (rs_rob_id == issue_qj)) begin
                iss_vj     = rs_value;
                iss_has_qj = 1'b0;
            end
        end
        iss_vk     = issue_vk;
        iss_has_qk = issue_has_qk;
        if (issue_has_qk) begin
            if (lsb_fi && (lsb_rob_id == issue_qk)) begin
                iss_vk     = lsb_value;
                iss_has_qk = 1'b0;
            end else if (rs_fi && (rs_rob_id == issue_qk)) begin
                iss_vk     = rs_value;
                iss_has_qk = 1'b0;
            end
        end
    end

    assign iss_accept = issue_valid && free_valid;

    always_comb begin
        count_next = count;
        case ({iss_accept, sel_valid})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    rs_alu u_alu (
        .op     (ent[sel_idx].op),
        .a      (ent[sel_idx].vj),
        .b      (ent[sel_idx].vk),
        .result (alu_result)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent[i] <= '0;
            end
            count     <= '0;
            rs_fi     <= 1'b0;
            rs_value  <= '0;
            rs_rob_id <= '0;
        end else if (rdy_in) begin
            if (rob_clear) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    ent[i].busy <= 1'b0;
                end
                count <= '0;
                rs_fi <= 1'b0;
            end else begin
                // Wakeup touches only operand fields of busy entries; issue only
                // writes a non-busy slot and dispatch only clears busy, so the
                // three never collide on the same field.
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (ent[i].busy && ent[i].has_qj) begin
                        if (lsb_fi && (lsb_rob_id == ent[i].qj)) begin
                            ent[i].vj     <= lsb_value;
                            ent[i].has_qj <= 1'b0;
                        end else if (rs_fi && (rs_rob_id == ent[i].qj)) begin
                            ent[i].vj     <= rs_value;
                            ent[i].has_qj <= 1'b0;
                        end
                    end
                    if (ent[i].busy && ent[i].has_qk) begin
                        if (lsb_fi && (lsb_rob_id == ent[i].qk)) begin
                            ent[i].vk     <= lsb_value;
                            ent[i].has_qk <= 1'b0;
                        end else if (rs_fi && (rs_rob_id == ent[i].qk)) begin
                            ent[i].vk     <= rs_value;
                            ent[i].has_qk <= 1'b0;
                        end
                    end
                end

                if (sel_valid) begin
                    ent[sel_idx].busy <= 1'b0;
                    rs_fi             <= 1'b1;
                    rs_value          <= alu_result;
                    rs_rob_id         <= ent[sel_idx].rob_id;
                end else begin
                    rs_fi <= 1'b0;
                end

                if (iss_accept) begin
                    ent[free_idx] <= '{busy:   1'b1,
                                       op:     issue_op,
                                       vj:     iss_vj,
                                       qj:     issue_qj,
                                       has_qj: iss_has_qj,
                                       vk:     iss_vk,
                                       qk:     issue_qk,
                                       has_qk: iss_has_qk,
                                       rob_id: issue_rob_id};
                end

                count <= count_next;
            end
        end
    end

endmodule
